// File: rtl/truth_table_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : truth_table_sequencer_pkg                          |
// | Description : Shared state encoding and default input count for  |
// |               the truth-table sweep sequencer.                   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package truth_table_sequencer_pkg;

  // Default number of function inputs (2^NIN vectors per sweep)
  localparam int NIN_DEFAULT = 4;

  // Sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/truth_table_sequencer_compare_acc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tts_compare_acc                                    |
// | Description : Mismatch counter and lowest-failing-vector capture |
// |               for the truth-table sequencer. With                |
// |               TRUTH_TABLE_CAPTURE_EN defined, also records both  |
// |               implementations' full truth tables.                |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tts_compare_acc
  import truth_table_sequencer_pkg::*;
#(
  parameter int NIN = NIN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [NIN-1:0]       vec,
  input  logic                 s_a,
  input  logic                 s_b,
  output logic [NIN:0]         mismatch_cnt,
  output logic [NIN-1:0]       first_bad,
  output logic                 first_bad_valid
`ifdef TRUTH_TABLE_CAPTURE_EN
  ,
  output logic [(1<<NIN)-1:0]  tt_a,
  output logic [(1<<NIN)-1:0]  tt_b
`endif
);

  logic differ;
  assign differ = s_a ^ s_b;

  // Count mismatching vectors and latch the first (lowest) one seen
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      mismatch_cnt    <= '0;
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else if (sample && differ) begin
      mismatch_cnt <= mismatch_cnt + (NIN+1)'(1);
      if (!first_bad_valid) begin
        first_bad       <= vec;
        first_bad_valid <= 1'b1;
      end
    end
  end

`ifdef TRUTH_TABLE_CAPTURE_EN
  // Record each implementation's output at the bit addressed by vec
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      tt_a <= '0;
      tt_b <= '0;
    end else if (sample) begin
      tt_a[vec] <= s_a;
      tt_b[vec] <= s_b;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/truth_table_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : truth_table_sequencer                              |
// | Description : Sweeps all 2^NIN input vectors through a reference |
// |               and a candidate combinational implementation and   |
// |               reports whether they are equivalent.               |
// |               Optional: TRUTH_TABLE_CAPTURE_EN adds tt_a/tt_b.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int NIN = NIN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 hold,
  input  logic                 s_a,
  input  logic                 s_b,
  output logic [NIN-1:0]       vec,
  output logic                 vec_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 equal,
  output logic [NIN:0]         mismatch_cnt,
  output logic [NIN-1:0]       first_bad,
  output logic                 first_bad_valid
`ifdef TRUTH_TABLE_CAPTURE_EN
  ,
  output logic [(1<<NIN)-1:0]  tt_a,
  output logic [(1<<NIN)-1:0]  tt_b
`endif
);

  state_t state;
  state_t state_next;
  logic   start_acc;
  logic   sample;
  logic   last_sample;

  assign start_acc   = (state == ST_IDLE) && start;
  assign sample      = (state == ST_RUN) && !hold;
  assign last_sample = sample && (&vec);

  assign vec_valid = sample;
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);

  // Next-state decode: DONE is a single-cycle pass-through back to IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)       state_next = ST_RUN;
      ST_RUN:  if (last_sample) state_next = ST_DONE;
      ST_DONE:                  state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // State, vector counter and equivalence verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      vec   <= '0;
      equal <= 1'b0;
    end else begin
      state <= state_next;
      if (start_acc) begin
        vec   <= '0;
        equal <= 1'b0;
      end else if (sample) begin
        // Wraps to zero naturally after the last vector
        vec <= vec + NIN'(1);
        // Verdict includes the last vector, which is being counted this edge
        if (last_sample)
          equal <= (mismatch_cnt == '0) && (s_a == s_b);
      end
    end
  end

  tts_compare_acc #(
    .NIN (NIN)
  ) u_compare_acc (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (start_acc),
    .sample          (sample),
    .vec             (vec),
    .s_a             (s_a),
    .s_b             (s_b),
    .mismatch_cnt    (mismatch_cnt),
    .first_bad       (first_bad),
    .first_bad_valid (first_bad_valid)
`ifdef TRUTH_TABLE_CAPTURE_EN
    ,
    .tt_a            (tt_a),
    .tt_b            (tt_b)
`endif
  );

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_truth_table_sequencer                           |
// | Description : Self-checking bench for truth_table_sequencer      |
// |               (NIN = 4). TRUTH_TABLE_CAPTURE_EN adds tt checks.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_truth_table_sequencer;

  localparam logic [15:0] REF_TT = 16'h212D;  // minterms {0,2,3,5,8,13}

  logic        clk = 1'b0;
  logic        rst_n, start, hold;
  logic        s_a, s_b;
  logic [3:0]  vec;
  logic        vec_valid, busy, done, equal, first_bad_valid;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_bad;
`ifdef TRUTH_TABLE_CAPTURE_EN
  logic [15:0] tt_a, tt_b;
`endif

  logic [15:0] ref_tt;
  logic [15:0] cand_tt;

  int checks   = 0;
  int failures = 0;

  // Both implementations are modelled as lookup tables addressed by vec
  assign s_a = ref_tt[vec];
  assign s_b = cand_tt[vec];

  always #5 clk = ~clk;

  truth_table_sequencer #(.NIN(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .hold            (hold),
    .s_a             (s_a),
    .s_b             (s_b),
    .vec             (vec),
    .vec_valid       (vec_valid),
    .busy            (busy),
    .done            (done),
    .equal           (equal),
    .mismatch_cnt    (mismatch_cnt),
    .first_bad       (first_bad),
    .first_bad_valid (first_bad_valid)
`ifdef TRUTH_TABLE_CAPTURE_EN
    ,
    .tt_a            (tt_a),
    .tt_b            (tt_b)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] cand;
    int          exp_cnt;
    int          exp_first;
    int          exp_fbv;
    int          exp_equal;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Start a sweep, optionally holding for hl cycles from cycle hs, and
  // track the vector sequence; cycle 1 is the first cycle after the start edge.
  task automatic do_sweep(input int hs, input int hl,
                          output int done_cyc, output int seq_err, output int eq_done);
    int exp_vec;
    seq_err  = 0;
    done_cyc = -1;
    eq_done  = -1;
    exp_vec  = 0;
    @(negedge clk); start = 1'b1; hold = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      hold = (c >= hs) && (c < hs + hl);
      #1;
      if (done) begin
        done_cyc = c;
        eq_done  = int'(equal);
        break;
      end
      if (!busy || vec != 4'(exp_vec) || vec_valid != !hold) seq_err++;
      if (!hold) exp_vec++;
      @(negedge clk);
    end
    hold = 1'b0;
    if (exp_vec != 16) seq_err++;
    @(negedge clk); #1;
    if (done || busy) seq_err++;
  endtask

  initial begin
    int dc, se, eqd, k;
    bit saw_done;

    tbl[0] = '{"cand_vec9",  REF_TT | 16'h0200, 1,  9,  1, 0};
    tbl[1] = '{"cand_inv",   ~REF_TT,           16, 0,  1, 0};
    tbl[2] = '{"cand_same",  REF_TT,            0,  0,  0, 1};
    tbl[3] = '{"cand_last",  REF_TT ^ 16'h8000, 1,  15, 1, 0};

    ref_tt  = REF_TT;
    cand_tt = REF_TT;
    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          int'({vec, vec_valid, busy, done, equal, mismatch_cnt, first_bad, first_bad_valid}), 0);
    rst_n = 1'b1;

    // Table-driven sweeps with distinct candidate functions
    for (int i = 0; i < 4; i++) begin
      cand_tt = tbl[i].cand;
      do_sweep(0, 0, dc, se, eqd);
      check({tbl[i].name, "_done_cycle"}, dc, 17);
      check({tbl[i].name, "_seq"}, se, 0);
      check({tbl[i].name, "_equal_at_done"}, eqd, tbl[i].exp_equal);
      repeat (2) @(negedge clk);
      #1;
      check({tbl[i].name, "_cnt"}, int'(mismatch_cnt), tbl[i].exp_cnt);
      check({tbl[i].name, "_first_bad"}, int'(first_bad), tbl[i].exp_first);
      check({tbl[i].name, "_fbv"}, int'(first_bad_valid), tbl[i].exp_fbv);
      check({tbl[i].name, "_equal"}, int'(equal), tbl[i].exp_equal);
`ifdef TRUTH_TABLE_CAPTURE_EN
      check({tbl[i].name, "_tt_a"}, int'(tt_a), int'(REF_TT));
      check({tbl[i].name, "_tt_b"}, int'(tt_b), int'(tbl[i].cand));
`endif
    end

    // Hold for 3 cycles while vec = 6 (vec 6 first presented in cycle 7)
    cand_tt = REF_TT;
    do_sweep(7, 3, dc, se, eqd);
    check("hold_done_cycle", dc, 20);
    check("hold_seq", se, 0);
    check("hold_equal", eqd, 1);

    // Reset in the middle of a sweep once vec reaches 7
    cand_tt = ~REF_TT;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    #1;
    while (!(busy && vec == 4'd7) && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    check("reach_vec7", int'(k < 40), 1);
    check("pre_reset_cnt", int'(mismatch_cnt), 7);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("abort_outputs",
          int'({vec, vec_valid, busy, done, equal, mismatch_cnt, first_bad, first_bad_valid}), 0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", int'(saw_done), 0);
    do_sweep(0, 0, dc, se, eqd);
    check("after_abort_done_cycle", dc, 17);
    check("after_abort_seq", se, 0);
    check("after_abort_cnt", int'(mismatch_cnt), 16);

    // start held high: one sweep, then a new one the cycle after IDLE
    cand_tt = REF_TT;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    dc = -1;
    for (int c = 1; c <= 60; c++) begin
      #1;
      if (done) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
    check("held_start_done_cycle", dc, 17);
    @(negedge clk); #1;
    check("held_start_idle", int'({busy, done}), 0);
    @(negedge clk); #1;
    check("held_start_restart", int'({busy, vec}), 16);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    check("held_start_second_done", int'(done), 1);
    check("held_start_second_equal", int'(equal), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
